// File: rtl/joy_serial_reader_if.sv
// ---------------------------------------------------------------------------
// joy_serial_reader_if
//   Bundles the shift-register chain pins and the decoded joystick words of
//   joy_serial_reader.
//
//   joy_data     chain serial output, 0 = pressed
//   joy_load_n   chain parallel load, active-low
//   joy_clk      chain shift clock, chain shifts on its rising edge
//   db9joy1_out  joystick 1 {F2,F1,U,D,L,R}, 0 = pressed
//   db9joy2_out  joystick 2, same format
//   scan_done    one-clk pulse per completed scan
//
//   master : the reader (drives the chain controls and the joystick words)
//   slave  : the chain / consumer side
// ---------------------------------------------------------------------------
interface joy_serial_reader_if;
    logic       joy_data;
    logic       joy_load_n;
    logic       joy_clk;
    logic [5:0] db9joy1_out;
    logic [5:0] db9joy2_out;
    logic       scan_done;

    modport master (
        input  joy_data,
        output joy_load_n,
        output joy_clk,
        output db9joy1_out,
        output db9joy2_out,
        output scan_done
    );

    modport slave (
        output joy_data,
        input  joy_load_n,
        input  joy_clk,
        input  db9joy1_out,
        input  db9joy2_out,
        input  scan_done
    );
endinterface

// File: rtl/joy_serial_reader.sv
// ---------------------------------------------------------------------------
// joy_serial_reader
//   Scans two DB9 joysticks through a 16-bit 74HC165-style parallel-in /
//   serial-out chain, debounces each stick over consecutive scans and
//   presents two active-low 6-bit words {F2,F1,U,D,L,R}.
//
//   Parameters
//     CLKDIV    clk cycles per scan tick (2..1023)
//     DEBOUNCE  identical consecutive scans needed before an output moves
//               (1..15)
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     joy    joy_serial_reader_if.master (chain pins, joystick words,
//            scan_done)
//
//   Chain layout: bits 0..5 = stick 1 R,L,D,U,F1,F2; bits 8..13 = stick 2
//   in the same order; bits 6,7,14,15 are unused.
// ---------------------------------------------------------------------------
module joy_serial_reader #(
    parameter int CLKDIV   = 64,
    parameter int DEBOUNCE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    joy_serial_reader_if.master   joy
);

    localparam logic [9:0] PRESC_MAX = 10'(CLKDIV - 1);
    localparam logic [3:0] DB_THRESH = 4'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        ST_START,
        ST_LOAD,
        ST_SAMPLE,
        ST_HIGH,
        ST_UPDATE
    } state_t;

    // -----------------------------------------------------------------------
    // Prescaler: one tick every CLKDIV clocks, on the last count.
    // -----------------------------------------------------------------------
    logic [9:0] presc_reg;
    logic [9:0] presc_next;
    logic       tick;

    assign tick = (presc_reg == PRESC_MAX);

    always_comb begin
        presc_next = presc_reg + 10'd1;
        if (tick) begin
            presc_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    // -----------------------------------------------------------------------
    // Scan FSM
    // -----------------------------------------------------------------------
    state_t      state_reg,     state_next;
    logic        load_n_reg,    load_n_next;
    logic        jclk_reg,      jclk_next;
    logic [3:0]  bitcnt_reg,    bitcnt_next;
    logic [15:0] shreg_reg,     shreg_next;
    logic        scan_done_reg, scan_done_next;
    logic        update_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_START;
            load_n_reg    <= 1'b1;
            jclk_reg      <= 1'b0;
            bitcnt_reg    <= '0;
            shreg_reg     <= '0;
            scan_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            load_n_reg    <= load_n_next;
            jclk_reg      <= jclk_next;
            bitcnt_reg    <= bitcnt_next;
            shreg_reg     <= shreg_next;
            scan_done_reg <= scan_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_n_next    = load_n_reg;
        jclk_next      = jclk_reg;
        bitcnt_next    = bitcnt_reg;
        shreg_next     = shreg_reg;
        scan_done_next = 1'b0;
        update_en      = 1'b0;

        if (tick) begin
            case (state_reg)
                ST_START: begin
                    load_n_next = 1'b0;
                    state_next  = ST_LOAD;
                end
                ST_LOAD: begin
                    load_n_next = 1'b1;
                    bitcnt_next = '0;
                    state_next  = ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    // The bit has been on the pin for a full low phase.
                    shreg_next[bitcnt_reg] = joy.joy_data;
                    jclk_next              = 1'b1;
                    state_next             = ST_HIGH;
                end
                ST_HIGH: begin
                    jclk_next = 1'b0;
                    if (bitcnt_reg == 4'd15) begin
                        state_next = ST_UPDATE;
                    end else begin
                        bitcnt_next = bitcnt_reg + 4'd1;
                        state_next  = ST_SAMPLE;
                    end
                end
                ST_UPDATE: begin
                    // scan_done rises on the same edge as the outputs change.
                    update_en      = 1'b1;
                    scan_done_next = 1'b1;
                    load_n_next    = 1'b0;
                    state_next     = ST_LOAD;
                end
                default: begin
                    state_next = ST_START;
                end
            endcase
        end
    end

    // An all-zero capture means no adapter is driving the chain; treat both
    // sticks as released rather than fully pressed.
    logic adapter_absent;
    assign adapter_absent = (shreg_reg == 16'h0000);

    // -----------------------------------------------------------------------
    // Per-stick debounce. Chain bits already line up with {F2,F1,U,D,L,R}.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_stick
        logic [5:0] raw;
        logic [5:0] prev_reg, prev_next;
        logic [3:0] cnt_reg,  cnt_next;
        logic [5:0] out_reg,  out_next;

        assign raw = adapter_absent ? 6'b111111 : shreg_reg[gi*8 +: 6];

        always_comb begin
            prev_next = prev_reg;
            cnt_next  = cnt_reg;
            out_next  = out_reg;
            if (update_en) begin
                if (raw == prev_reg) begin
                    cnt_next = (cnt_reg == 4'd15) ? 4'd15 : cnt_reg + 4'd1;
                end else begin
                    cnt_next = 4'd0;
                end
                prev_next = raw;
                if (cnt_next >= DB_THRESH) begin
                    out_next = raw;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_reg <= 6'b111111;
                cnt_reg  <= '0;
                out_reg  <= 6'b111111;
            end else begin
                prev_reg <= prev_next;
                cnt_reg  <= cnt_next;
                out_reg  <= out_next;
            end
        end
    end

    assign joy.joy_load_n  = load_n_reg;
    assign joy.joy_clk     = jclk_reg;
    assign joy.scan_done   = scan_done_reg;
    assign joy.db9joy1_out = g_stick[0].out_reg;
    assign joy.db9joy2_out = g_stick[1].out_reg;

endmodule

// File: tb/tb_joy_serial_reader.sv
// ---------------------------------------------------------------------------
// tb_joy_serial_reader
//   Two readers with CLKDIV=4: dut_a uses DEBOUNCE=3, dut_b DEBOUNCE=1.
//   Each has a behavioural 74HC165 chain whose parallel inputs come from
//   pattern[i] (bit n appears on the pin after n shifts).
// ---------------------------------------------------------------------------
module tb_joy_serial_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a;
    logic rst_n_b;

    joy_serial_reader_if if_a();
    joy_serial_reader_if if_b();

    joy_serial_reader #(.CLKDIV(4), .DEBOUNCE(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .joy   (if_a.master)
    );

    joy_serial_reader #(.CLKDIV(4), .DEBOUNCE(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .joy   (if_b.master)
    );

    logic        load_n_w [2];
    logic        jclk_w   [2];
    logic        done_w   [2];
    logic [5:0]  j1_w     [2];
    logic [5:0]  j2_w     [2];

    assign load_n_w[0] = if_a.joy_load_n;
    assign load_n_w[1] = if_b.joy_load_n;
    assign jclk_w[0]   = if_a.joy_clk;
    assign jclk_w[1]   = if_b.joy_clk;
    assign done_w[0]   = if_a.scan_done;
    assign done_w[1]   = if_b.scan_done;
    assign j1_w[0]     = if_a.db9joy1_out;
    assign j1_w[1]     = if_b.db9joy1_out;
    assign j2_w[0]     = if_a.db9joy2_out;
    assign j2_w[1]     = if_b.db9joy2_out;

    // Chain models
    logic [15:0] pattern [2];
    logic [15:0] sr      [2];
    logic        jclk_d  [2];

    assign if_a.joy_data = sr[0][0];
    assign if_b.joy_data = sr[1][0];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            jclk_d[i] <= jclk_w[i];
            if (!load_n_w[i])
                sr[i] <= pattern[i];
            else if (jclk_w[i] && !jclk_d[i])
                sr[i] <= {1'b1, sr[i][15:1]};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic release_rst(input int sel);
        @(posedge clk);
        #1;
        if (sel == 0) rst_n_a = 1'b1;
        else          rst_n_b = 1'b1;
    endtask

    // Entered in cycle 0 after reset release; checks cycles 0..n-1 against
    // the expected chain waveform and leaves the bench in cycle n.
    task automatic frame_check(input int sel, input int n, input bit outs_released);
        for (int c = 0; c < n; c++) begin
            int   p;
            logic exp_load;
            logic exp_clk;
            logic exp_done;
            exp_load = 1'b1;
            exp_clk  = 1'b0;
            exp_done = 1'b0;
            if (c >= 4) begin
                p = (c - 4) % 136;
                exp_load = !(p < 4);
                if (p >= 4 && p < 132)
                    exp_clk = (((p - 4) / 4) % 2) == 1;
            end
            if (c >= 140 && ((c - 140) % 136) == 0)
                exp_done = 1'b1;
            chk($sformatf("load_n c%0d", c), 16'(load_n_w[sel]), 16'(exp_load));
            chk($sformatf("joy_clk c%0d", c), 16'(jclk_w[sel]), 16'(exp_clk));
            chk($sformatf("scan_done c%0d", c), 16'(done_w[sel]), 16'(exp_done));
            if (outs_released) begin
                chk($sformatf("joy1 c%0d", c), 16'(j1_w[sel]), 16'h003F);
                chk($sformatf("joy2 c%0d", c), 16'(j2_w[sel]), 16'h003F);
            end
            step();
        end
    endtask

    // Advance until the next scan_done pulse (bounded).
    task automatic wait_scan(input int sel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (done_w[sel] === 1'b1) seen = 1'b1;
        end
        chk("scan_timeout", 16'(seen), 16'h0001);
        $display("scan dut%0d t=%0t joy1=%b joy2=%b", sel, $time, j1_w[sel], j2_w[sel]);
    endtask

    initial begin
        rst_n_a    = 1'b0;
        rst_n_b    = 1'b0;
        pattern[0] = 16'hFFFF;
        pattern[1] = 16'hDFFE;
        step(3);

        // Reset values
        chk("rst load_n", 16'(if_a.joy_load_n), 16'h0001);
        chk("rst joy_clk", 16'(if_a.joy_clk), 16'h0000);
        chk("rst scan_done", 16'(if_a.scan_done), 16'h0000);
        chk("rst joy1", 16'(if_a.db9joy1_out), 16'h003F);
        chk("rst joy2", 16'(if_a.db9joy2_out), 16'h003F);
        chk("rst b joy1", 16'(if_b.db9joy1_out), 16'h003F);

        // Frame timing, all released
        release_rst(0);
        frame_check(0, 300, 1'b1);

        // Debounce: stick 1 fire1 pressed from scan k
        wait_scan(0);
        pattern[0] = 16'hFFEF;
        wait_scan(0);
        chk("deb k joy1", 16'(j1_w[0]), 16'h003F);
        wait_scan(0);
        chk("deb k+1 joy1", 16'(j1_w[0]), 16'h003F);
        wait_scan(0);
        chk("deb k+2 joy1", 16'(j1_w[0]), 16'h002F);
        chk("deb k+2 joy2", 16'(j2_w[0]), 16'h003F);
        wait_scan(0);
        chk("deb k+3 joy1", 16'(j1_w[0]), 16'h002F);

        // Release, then a two-scan glitch on stick 2 up
        pattern[0] = 16'hFFFF;
        wait_scan(0);
        chk("rel 1 joy1", 16'(j1_w[0]), 16'h002F);
        wait_scan(0);
        wait_scan(0);
        chk("rel 3 joy1", 16'(j1_w[0]), 16'h003F);
        pattern[0] = 16'hF7FF;
        for (int s = 0; s < 2; s++) begin
            wait_scan(0);
            chk($sformatf("glitch on %0d joy2", s), 16'(j2_w[0]), 16'h003F);
        end
        pattern[0] = 16'hFFFF;
        for (int s = 0; s < 3; s++) begin
            wait_scan(0);
            chk($sformatf("glitch off %0d joy2", s), 16'(j2_w[0]), 16'h003F);
        end

        // Both sticks, DEBOUNCE=1: bits 0 and 13 pressed
        release_rst(1);
        frame_check(1, 140, 1'b0);
        chk("both done", 16'(done_w[1]), 16'h0001);
        chk("both joy1", 16'(j1_w[1]), 16'h003E);
        chk("both joy2", 16'(j2_w[1]), 16'h001F);

        // Only an unused bit high: every button pressed
        pattern[1] = 16'h8000;
        wait_scan(1);
        chk("allpress joy1", 16'(j1_w[1]), 16'h0000);
        chk("allpress joy2", 16'(j2_w[1]), 16'h0000);

        // Adapter absent
        pattern[1] = 16'h0000;
        for (int s = 0; s < 2; s++) begin
            wait_scan(1);
            chk($sformatf("absent %0d joy1", s), 16'(j1_w[1]), 16'h003F);
            chk($sformatf("absent %0d joy2", s), 16'(j2_w[1]), 16'h003F);
        end

        // Mid-scan reset while showing pressed
        pattern[1] = 16'hDFFE;
        wait_scan(1);
        chk("pre joy1", 16'(j1_w[1]), 16'h003E);
        chk("pre joy2", 16'(j2_w[1]), 16'h001F);
        step(65);
        chk("bit7 high joy_clk", 16'(jclk_w[1]), 16'h0001);
        rst_n_b = 1'b0;
        #1;
        chk("mid rst joy1", 16'(j1_w[1]), 16'h003F);
        chk("mid rst joy2", 16'(j2_w[1]), 16'h003F);
        chk("mid rst joy_clk", 16'(jclk_w[1]), 16'h0000);
        chk("mid rst load_n", 16'(load_n_w[1]), 16'h0001);
        chk("mid rst scan_done", 16'(done_w[1]), 16'h0000);
        step(2);
        release_rst(1);
        frame_check(1, 140, 1'b0);
        chk("restart done", 16'(done_w[1]), 16'h0001);
        chk("restart joy1", 16'(j1_w[1]), 16'h003E);
        chk("restart joy2", 16'(j2_w[1]), 16'h001F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/joy_serial_reader.md
# joy_serial_reader

Scans two DB9 joysticks through an external 74HC165-style parallel-in/serial-out shift-register chain. Drives the chain's load and shift-clock lines and debounces each joystick over consecutive scans. Presents two 6-bit active-low joystick words in the {fire2, fire1, up, down, left, right} order expected by the joystick protocol decoder, which consumes them directly as its DB9 inputs.

## Interface
Parameters:
- CLKDIV, 64: `clk` cycles per scan tick; legal range 2..1023.
- DEBOUNCE, 3: consecutive identical scans needed before an output changes; legal range 1..15.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- joy_data  in  1  serial data from the chain output pin; 0 = pressed.
- joy_load_n  out  1  chain parallel load; active-low.
- joy_clk  out  1  chain shift clock; the chain shifts on the rising edge.
- db9joy1_out  out  6  joystick 1 as {F2,F1,U,D,L,R}; 0 = pressed.
- db9joy2_out  out  6  joystick 2, same format.
- scan_done  out  1  one-`clk` pulse per completed scan.

## Operation
- **Prescaler**
  - Counts 0..CLKDIV-1 and wraps.
  - A tick is the `clk` cycle in which the count equals CLKDIV-1.
  - All FSM transitions and all output-register updates happen only on ticks.
- **Chain**
  - Fixed length of 16 bits; bit n is captured in shift position n.
  - Bits 0..5 are joystick 1: R, L, D, U, F1, F2.
  - Bits 8..13 are joystick 2: R, L, D, U, F1, F2.
  - Bits 6, 7, 14 and 15 are unused.
- **FSM states:** START, LOAD, SAMPLE, HIGH, UPDATE.
  - START (reset state). On a tick: joy_load_n <= 0, go to LOAD.
  - LOAD. On a tick: joy_load_n <= 1, bitcnt <= 0, go to SAMPLE.
  - SAMPLE (joy_clk = 0). On a tick: shreg[bitcnt] <= joy_data, joy_clk <= 1, go to HIGH.
  - HIGH. On a tick: joy_clk <= 0.
    - If bitcnt = 15, go to UPDATE.
    - Otherwise bitcnt <= bitcnt+1 and go to SAMPLE.
  - UPDATE. On a tick: run the debounce step, pulse scan_done, joy_load_n <= 0, go to LOAD.
- **Adapter-absent rule:** if all 16 captured bits are 0, both raw words for that scan are forced to 6'b111111 (released).
- **Debounce step** (each joystick independently; raw = this scan's 6 bits, prev = previous raw, cnt = 4-bit counter):
  - If raw == prev, cnt_next = cnt+1 saturating at 15; otherwise cnt_next = 0.
  - prev <= raw; cnt <= cnt_next.
  - If cnt_next >= DEBOUNCE-1, the output <= raw; otherwise the output holds.
  - With DEBOUNCE=1 the output follows every scan.
- **Unused bits** affect only the adapter-absent check.

## Timing
- **Reset values** (applied immediately and asynchronously, including mid-scan):
  - joy_load_n = 1, joy_clk = 0, scan_done = 0.
  - db9joy1_out = db9joy2_out = 6'b111111.
  - prev = 6'b111111, cnt = 0, prescaler = 0, state = START.
- **Reset mid-scan:** the partial scan is discarded, and the next scan restarts from START.
- **After reset release**, the first tick occurs at `clk` cycle CLKDIV-1. joy_load_n then stays low for exactly CLKDIV cycles.
- **Scan period:** 34 ticks = 34·CLKDIV `clk` cycles (1 LOAD + 32 shift + 1 UPDATE). The first scan additionally includes one START tick.
- **joy_clk:** high and low phases are each CLKDIV cycles. Each bit is sampled on the tick that ends its low phase, at least one tick after the load or shift that produced it.
- **scan_done** is high for the single `clk` of the UPDATE tick. The outputs take their new values on the same edge.
- **Worst-case latency** from a stable press to an output change is DEBOUNCE+1 scan periods.

## Test plan
- **Reset and frame timing** (CLKDIV=4; chain model of 16 released bits, with bit 15 = 1 so the scan is non-zero).
  - After rst_n rises, joy_load_n is low from cycle 4 to cycle 8.
  - 16 joy_clk pulses follow, each 4 high / 4 low.
  - scan_done repeats every 136 cycles.
  - Outputs stay 6'b111111 throughout.
- **Debounce** (DEBOUNCE=3; joystick 1 fire1 pressed, bit 4 = 0, from scan k).
  - db9joy1_out stays 6'b111111 through scan k+1.
  - It becomes 6'b101111 at scan_done of scan k+2.
  - db9joy2_out is unchanged.
- **Glitch rejection** (DEBOUNCE=3; joystick 2 up pressed, bit 11 = 0, for two scans, then released).
  - db9joy2_out stays 6'b111111 throughout.
- **Both sticks** (DEBOUNCE=1; bits 0 and 13 pressed).
  - db9joy1_out = 6'b111110 and db9joy2_out = 6'b011111 at the first scan_done.
- **Adapter absent** (DEBOUNCE=1; joy_data tied to 0).
  - Both outputs stay 6'b111111 on every scan.
- **Mid-scan reset** (assert rst_n low during shift of bit 7 while a button is held and the outputs show pressed).
  - Outputs return to 6'b111111 within the same cycle; joy_clk = 0, joy_load_n = 1.
  - After release, timing restarts exactly as in the first scenario.
